// File: rtl/mul_seq_unit.sv
// rtl/mul_seq_unit.sv - 32-cycle sequential shift-add multiplier, low 32 bits of product
module mul_seq_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_in,
    input  logic        signed_in,
    input  logic [0:31] busA_in,
    input  logic [0:31] busB_in,
    input  logic        flush_in,
    output logic [0:31] result_out,
    output logic        busy_out,
    output logic        done_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sign_q, sign_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [31:0] a_raw, b_raw, a_abs, b_abs, acc_sum;

    // Next-state and datapath: capture magnitudes on start, one shift-add step per BUSY cycle
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;

        a_raw   = busA_in;
        b_raw   = busB_in;
        a_abs   = (signed_in && a_raw[31]) ? (32'd0 - a_raw) : a_raw;
        b_abs   = (signed_in && b_raw[31]) ? (32'd0 - b_raw) : b_raw;
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

        if (flush_in) begin
            // Squash wins over everything; the last delivered result stays visible
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_in) begin
                        mcand_d  = a_abs;
                        mplier_d = b_abs;
                        sign_d   = signed_in & (a_raw[31] ^ b_raw[31]);
                        acc_d    = 32'd0;
                        cnt_d    = 6'd0;
                        state_d  = ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        result_d = sign_q ? (32'd0 - acc_sum) : acc_sum;
                        state_d  = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_BUSY);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
            result_q <= 32'd0;
            cnt_q    <= 6'd0;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result_out = result_q;
    assign busy_out   = busy_q;
    assign done_out   = done_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// tb/tb_mul_seq_unit.sv - directed self-checking bench for mul_seq_unit
module tb_mul_seq_unit;

    logic        clk;
    logic        reset;
    logic        start_in;
    logic        signed_in;
    logic [0:31] busA_in;
    logic [0:31] busB_in;
    logic        flush_in;
    logic [0:31] result_out;
    logic        busy_out;
    logic        done_out;

    int checks = 0;
    int errors = 0;

    mul_seq_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start_in   (start_in),
        .signed_in  (signed_in),
        .busA_in    (busA_in),
        .busB_in    (busB_in),
        .flush_in   (flush_in),
        .result_out (result_out),
        .busy_out   (busy_out),
        .done_out   (done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op at E0, then watch up to 40 edges; dk = edge index of done (0 if never)
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] res, output int nbusy, output int dk);
        busA_in = a; busB_in = b; signed_in = s; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        nbusy = busy_out ? 1 : 0;
        dk = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done_out) begin
                dk = k;
                break;
            end
            if (busy_out) nbusy++;
        end
        res = result_out;
    endtask

    task automatic test_reset();
        reset = 1'b0; start_in = 0; signed_in = 0; flush_in = 0;
        busA_in = 32'h0; busB_in = 32'h0;
        #12;
        checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || result_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b result=%h required 0 0 00000000", busy_out, done_out, result_out);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        logic [31:0] r; int nb, dk;
        run_op(32'h7, 32'h6, 1'b0, r, nb, dk);
        checks++;
        if (nb !== 32 || dk !== 32) begin
            errors++;
            $display("FAIL unsigned_latency busy_cycles=%0d done_edge=%0d required 32 32", nb, dk);
        end
        checks++;
        if (r !== 32'h0000002A || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_7x6 result=%h busy=%b required 0000002a 0", r, busy_out);
        end
        @(posedge clk); #1;
        checks++;
        if (done_out !== 1'b0 || result_out !== 32'h2A) begin
            errors++;
            $display("FAIL done_one_cycle done=%b result=%h required 0 0000002a", done_out, result_out);
        end
    endtask

    task automatic test_signed();
        logic [31:0] r; int nb, dk;
        run_op(32'hFFFFFFFD, 32'h5, 1'b1, r, nb, dk);
        checks++;
        if (r !== 32'hFFFFFFF1 || dk !== 32) begin
            errors++;
            $display("FAIL signed_m3x5 result=%h done_edge=%0d required fffffff1 32", r, dk);
        end
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, r, nb, dk);
        checks++;
        if (r !== 32'h80000000 || dk !== 32) begin
            errors++;
            $display("FAIL signed_min_x_m1 result=%h done_edge=%0d required 80000000 32", r, dk);
        end
        run_op(32'hFFFFFFFD, 32'h5, 1'b0, r, nb, dk);
        checks++;
        if (r !== 32'hFFFFFFF1 || dk !== 32) begin
            errors++;
            $display("FAIL unsigned_big_x5 result=%h done_edge=%0d required fffffff1 32", r, dk);
        end
        run_op(32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1, r, nb, dk);
        checks++;
        if (r !== 32'h00000006 || dk !== 32) begin
            errors++;
            $display("FAIL signed_m2xm3 result=%h done_edge=%0d required 00000006 32", r, dk);
        end
    endtask

    task automatic test_truncation();
        logic [31:0] r; int nb, dk;
        run_op(32'h00010000, 32'h00010000, 1'b0, r, nb, dk);
        checks++;
        if (r !== 32'h0 || dk !== 32) begin
            errors++;
            $display("FAIL trunc_2p32 result=%h done_edge=%0d required 00000000 32", r, dk);
        end
        run_op(32'h0, 32'h12345678, 1'b0, r, nb, dk);
        checks++;
        if (r !== 32'h0 || dk !== 32 || nb !== 32) begin
            errors++;
            $display("FAIL zero_operand result=%h done_edge=%0d busy_cycles=%0d required 00000000 32 32", r, dk, nb);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        busA_in = 32'h9; busB_in = 32'h9; signed_in = 0; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || result_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_op busy=%b done=%b result=%h required 0 0 00000000", busy_out, done_out, result_out);
        end
        #3 reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done_out || busy_out) seen++;
        end
        checks++;
        if (seen !== 0 || result_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_lost_op activity=%0d result=%h required 0 00000000", seen, result_out);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r; int nb, dk, seen;
        run_op(32'h7, 32'h6, 1'b0, r, nb, dk);
        busA_in = 32'h3; busB_in = 32'h3; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (5) @(posedge clk);
        #1 flush_in = 1'b1;
        @(posedge clk); #1;
        flush_in = 1'b0;
        checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || result_out !== 32'h2A) begin
            errors++;
            $display("FAIL flush_busy busy=%b done=%b result=%h required 0 0 0000002a", busy_out, done_out, result_out);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done_out || busy_out || result_out !== 32'h2A) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_no_done bad_cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int nb, dk;
        run_op(32'h7, 32'h6, 1'b0, r, nb, dk);
        checks++;
        if (done_out !== 1'b1 || r !== 32'h2A) begin
            errors++;
            $display("FAIL b2b_first done=%b result=%h required 1 0000002a", done_out, r);
        end
        busA_in = 32'h3; busB_in = 32'h4; signed_in = 0; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        checks++;
        if (busy_out !== 1'b1 || done_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart busy=%b done=%b required 1 0", busy_out, done_out);
        end
        dk = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done_out) begin
                dk = k;
                break;
            end
        end
        checks++;
        if (dk !== 32 || result_out !== 32'h0000000C) begin
            errors++;
            $display("FAIL b2b_second done_edge=%0d result=%h required 32 0000000c", dk, result_out);
        end
    endtask

    task automatic test_ignore_start();
        int dk;
        busA_in = 32'd100; busB_in = 32'd3; signed_in = 0; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        dk = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k >= 4 && k <= 12) begin
                start_in  = k[0];
                signed_in = 1'b1;
                busA_in   = 32'hDEAD0000 + k;
                busB_in   = 32'h0BEEF000 - k;
            end else begin
                start_in = 1'b0;
            end
            @(posedge clk); #1;
            if (done_out) begin
                dk = k;
                break;
            end
        end
        start_in = 1'b0;
        checks++;
        if (dk !== 32 || result_out !== 32'h0000012C) begin
            errors++;
            $display("FAIL ignore_start done_edge=%0d result=%h required 32 0000012c", dk, result_out);
        end
        @(posedge clk); #1;
        start_in = 1'b1; flush_in = 1'b1;
        busA_in = 32'h5; busB_in = 32'h5; signed_in = 0;
        @(posedge clk); #1;
        start_in = 1'b0; flush_in = 1'b0;
        checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || result_out !== 32'h12C) begin
            errors++;
            $display("FAIL flush_start_idle busy=%b done=%b result=%h required 0 0 0000012c", busy_out, done_out, result_out);
        end
        @(posedge clk); #1;
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_start_stays_idle busy=%b required 0", busy_out);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_truncation();
        test_reset_mid();
        test_flush();
        test_back_to_back();
        test_ignore_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq_unit.md
MUL_SEQ_UNIT -- requirements
Module: mul_seq_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start_in, input, 1 bit: ID-stage multiply control bit ANDed with instruction-valid; requests a multiply.
REQ-004 SHALL have port signed_in, input, 1 bit: 1 = signed multiply (mult), 0 = unsigned multiply (multu).
REQ-005 SHALL have port busA_in, input, 32 bits [0:31], bit 0 MSB: multiplicand from ALU operand A.
REQ-006 SHALL have port busB_in, input, 32 bits [0:31], bit 0 MSB: multiplier from ALU operand B.
REQ-007 SHALL have port flush_in, input, 1 bit: synchronous abort from branch/trap squash.
REQ-008 SHALL have port result_out, output, 32 bits [0:31]: low 32 bits of the product.
REQ-009 SHALL have port busy_out, output, 1 bit: stall request to IF/ID; high while BUSY.
REQ-010 SHALL have port done_out, output, 1 bit: one-cycle pulse; result_out is valid.

Function
REQ-011 SHALL implement three states: IDLE, BUSY, DONE.
REQ-012 SHALL, in IDLE or DONE with start_in=1 and flush_in=0 at a rising edge (edge E0), capture operands, clear the 6-bit counter and accumulator, and enter BUSY.
REQ-013 SHALL, when signed_in=1 at E0, capture |busA_in| and |busB_in| as 32-bit unsigned values (0x80000000 -> 2^31) and record the result sign as busA_in[0] XOR busB_in[0]; when signed_in=0, capture the operands unmodified with sign 0.
REQ-014 SHALL, on each BUSY edge, add the shifted multiplicand to a 32-bit accumulator when the current multiplier LSB is 1, shift the multiplier right and the multiplicand left by one, and increment the counter.
REQ-015 SHALL leave BUSY for DONE on the 32nd BUSY edge (E32); latency is fixed at 32 cycles regardless of operand values, including zero.
REQ-016 SHALL, on entering DONE, load result_out with the accumulator, two's-complement negated when the recorded sign is 1; bits above 32 are discarded with no overflow flag.
REQ-017 SHALL drive busy_out=1 exactly in BUSY, and done_out=1 exactly in DONE (one cycle).
REQ-018 SHALL move from DONE to IDLE at the next edge unless start_in=1, in which case a new operation is accepted per REQ-012 (back-to-back, no bubble).
REQ-019 SHALL ignore start_in while BUSY; the captured operands are not disturbed by input changes.
REQ-020 SHALL hold result_out unchanged from DONE until the next DONE entry or reset.
REQ-021 SHALL, on flush_in=1 at an edge in any state, enter IDLE, leave result_out unchanged, and suppress done_out; flush_in wins over simultaneous start_in.

Reset
REQ-022 SHALL, while reset=0, immediately and asynchronously force state IDLE, counter 0, accumulator 0, result_out 0x00000000, busy_out 0, done_out 0, including mid-operation.
REQ-023 SHALL resume normal operation from the first rising edge after reset returns to 1; an operation in progress at reset is lost.

Verification
REQ-024 Unsigned 0x00000007 x 0x00000006, start at E0 -> busy_out high for cycles after E0..E31, done_out pulses after E32, result_out 0x0000002A.
REQ-025 Signed 0xFFFFFFFD (-3) x 0x00000005 -> result_out 0xFFFFFFF1; signed 0x80000000 x 0xFFFFFFFF -> 0x80000000.
REQ-026 Unsigned 0x00010000 x 0x00010000 -> result_out 0x00000000 (truncation); 0x00000000 x 0x12345678 -> 0x00000000 after 32 cycles.
REQ-027 Reset low at BUSY cycle 10 -> busy_out 0, result_out 0x00000000 immediately, no done_out; flush_in at BUSY cycle 5 with prior result 0x2A -> IDLE, result_out stays 0x0000002A, no done_out.
REQ-028 start_in high during DONE with 3 x 4 unsigned -> done_out for the first op, busy_out rises the next cycle, second done_out after 32 more cycles, result_out 0x0000000C.
REQ-029 start_in toggled and operands changed mid-BUSY, plus start_in and flush_in asserted together in IDLE -> first result is unaffected; the simultaneous case stays IDLE.
